// File: rtl/prng_pkg.sv
// Shared types and helpers for the LFSR random-number bank and its arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package prng_pkg;

  typedef enum logic [1:0] {
    UNSEEDED = 2'd0,
    WARMUP   = 2'd1,
    READY    = 2'd2
  } state_e;

  localparam int LANE_W    = 16;
  localparam int NUM_LANES = 4;

  typedef logic [LANE_W-1:0] lane_t;

  // An all-zero LFSR never leaves zero, so a zero seed slice loads this instead.
  localparam lane_t ZERO_SEED_SUB = 16'h0001;

  // One shift-left step of the 16-bit LFSR, taps 3/12/14/15.
  function automatic lane_t lfsr16_next(input lane_t s);
    return {s[14:0], s[3] ^ s[12] ^ s[14] ^ s[15]};
  endfunction

endpackage

// File: rtl/lfsr16_lane.sv
// One 16-bit LFSR lane register with load (zero-seed substitution) and step enable.
// Latency: load/step take effect at the next rising edge.
// Backpressure: none; load has priority over step.
module lfsr16_lane
  import prng_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  load,
  input  lane_t load_val,
  input  logic  step,
  output lane_t lane_q
);

  lane_t lane_d;

  // Next lane value: load wins, otherwise step when enabled, otherwise hold.
  always_comb begin
    lane_d = lane_q;
    if (load) begin
      lane_d = (load_val == '0) ? ZERO_SEED_SUB : load_val;
    end else if (step) begin
      lane_d = lfsr16_next(lane_q);
    end
  end

  // Lane register; contents are lost on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) lane_q <= '0;
    else       lane_q <= lane_d;
  end

endmodule

// File: rtl/prng_arbiter.sv
// Round-robin arbiter handing out one 16-bit word per cycle from a rotating bank of four LFSR lanes.
// Latency: 1 cycle req->gnt/rnd_data; optional warm-up (macro PRNG_ARB_WARMUP_EN) of WARMUP_CYCLES after each load.
// Backpressure: none; requesters hold req until granted, at most one grant per cycle, worst-case wait NREQ cycles.
module prng_arbiter
  import prng_pkg::*;
#(
  parameter int NREQ          = 4,
  parameter int WARMUP_CYCLES = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            seed_load,
  input  logic [63:0]     seed,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic            rnd_valid,
  output logic [15:0]     rnd_data,
  output logic [1:0]      rnd_lane,
  output logic            seeded
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_e            state_q, state_d;
  logic [1:0]        lane_ptr_q, lane_ptr_d;
  logic [IW-1:0]     last_grant_q, last_grant_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic              rnd_valid_q, rnd_valid_d;
  lane_t             rnd_data_q, rnd_data_d;
  logic [1:0]        rnd_lane_q, rnd_lane_d;
  lane_t             lane_val [NUM_LANES];
  logic [NUM_LANES-1:0] lane_step;

  logic              win_found;
  logic [IW-1:0]     win_idx;
  logic [IW-1:0]     cand;
  int                idx;

`ifdef PRNG_ARB_WARMUP_EN
  logic [15:0]       warm_cnt_q, warm_cnt_d;
`else
  logic              unused_warmup;
  assign unused_warmup = (WARMUP_CYCLES != 0);
`endif

  generate
    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
      lfsr16_lane u_lane (
        .clk      (clk),
        .reset    (reset),
        .load     (seed_load),
        .load_val (seed[16*k +: 16]),
        .step     (lane_step[k]),
        .lane_q   (lane_val[k])
      );
    end
  endgenerate

  // Round-robin search upward from the requester after the last winner, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_idx   = last_grant_q;
    idx       = 0;
    cand      = '0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = int'(last_grant_q) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      cand = IW'(idx);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Next state, lane stepping and registered grant outputs; seed_load overrides all.
  always_comb begin
    state_d      = state_q;
    lane_ptr_d   = lane_ptr_q;
    last_grant_d = last_grant_q;
    gnt_d        = '0;
    rnd_valid_d  = 1'b0;
    rnd_data_d   = rnd_data_q;
    rnd_lane_d   = rnd_lane_q;
    lane_step    = '0;
`ifdef PRNG_ARB_WARMUP_EN
    warm_cnt_d   = warm_cnt_q;
`endif
    if (seed_load) begin
      lane_ptr_d   = '0;
      last_grant_d = IW'(NREQ - 1);
`ifdef PRNG_ARB_WARMUP_EN
      warm_cnt_d   = '0;
      state_d      = WARMUP;
`else
      state_d      = READY;
`endif
    end else begin
      case (state_q)
        UNSEEDED: ;
`ifdef PRNG_ARB_WARMUP_EN
        WARMUP: begin
          lane_step  = '1;
          warm_cnt_d = warm_cnt_q + 16'd1;
          if (warm_cnt_q == 16'(WARMUP_CYCLES - 1)) state_d = READY;
        end
`endif
        READY: begin
          if (win_found) begin
            gnt_d                 = {{(NREQ-1){1'b0}}, 1'b1} << win_idx;
            rnd_valid_d           = 1'b1;
            rnd_data_d            = lane_val[lane_ptr_q];
            rnd_lane_d            = lane_ptr_q;
            lane_step[lane_ptr_q] = 1'b1;
            lane_ptr_d            = lane_ptr_q + 2'd1;
            last_grant_d          = win_idx;
          end
        end
        default: state_d = UNSEEDED;
      endcase
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= UNSEEDED;
      lane_ptr_q   <= '0;
      last_grant_q <= IW'(NREQ - 1);
      gnt_q        <= '0;
      rnd_valid_q  <= 1'b0;
      rnd_data_q   <= '0;
      rnd_lane_q   <= '0;
`ifdef PRNG_ARB_WARMUP_EN
      warm_cnt_q   <= '0;
`endif
    end else begin
      state_q      <= state_d;
      lane_ptr_q   <= lane_ptr_d;
      last_grant_q <= last_grant_d;
      gnt_q        <= gnt_d;
      rnd_valid_q  <= rnd_valid_d;
      rnd_data_q   <= rnd_data_d;
      rnd_lane_q   <= rnd_lane_d;
`ifdef PRNG_ARB_WARMUP_EN
      warm_cnt_q   <= warm_cnt_d;
`endif
    end
  end

  assign gnt       = gnt_q;
  assign rnd_valid = rnd_valid_q;
  assign rnd_data  = rnd_data_q;
  assign rnd_lane  = rnd_lane_q;
  assign seeded    = (state_q == READY);

endmodule

// File: tb/tb_prng_arbiter.sv
// Directed bench for prng_arbiter: reset, seeding, rotation, round-robin, reload and async reset.
// Latency: expects grants one edge after req; warm-up length follows PRNG_ARB_WARMUP_EN.
// Backpressure: n/a.
module tb_prng_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 16;
`ifdef PRNG_ARB_WARMUP_EN
  localparam int EXP_WARM = W;
`else
  localparam int EXP_WARM = 0;
`endif

  logic            clk;
  logic            reset;
  logic            seed_load;
  logic [63:0]     seed;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] gnt;
  logic            rnd_valid;
  logic [15:0]     rnd_data;
  logic [1:0]      rnd_lane;
  logic            seeded;

  int checks = 0;
  int errors = 0;

  logic [15:0] m_lane [4];
  int          m_ptr;

  prng_arbiter #(.NREQ(NREQ), .WARMUP_CYCLES(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .seed_load (seed_load),
    .seed      (seed),
    .req       (req),
    .gnt       (gnt),
    .rnd_valid (rnd_valid),
    .rnd_data  (rnd_data),
    .rnd_lane  (rnd_lane),
    .seeded    (seeded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] ref_next(input logic [15:0] s);
    return {s[14:0], s[3] ^ s[12] ^ s[14] ^ s[15]};
  endfunction

  task automatic model_load(input logic [63:0] s);
    for (int k = 0; k < 4; k++) begin
      m_lane[k] = s[16*k +: 16];
      if (m_lane[k] == 16'h0) m_lane[k] = 16'h0001;
    end
    m_ptr = 0;
    for (int c = 0; c < EXP_WARM; c++)
      for (int k = 0; k < 4; k++) m_lane[k] = ref_next(m_lane[k]);
  endtask

  // Load a seed with req driven alongside, then wait for READY.
  task automatic do_load(input logic [63:0] s, input logic [NREQ-1:0] r);
    int n;
    seed      = s;
    seed_load = 1'b1;
    req       = r;
    tick();
    seed_load = 1'b0;
    model_load(s);
    check("load_gnt", gnt, 0);
    check("load_valid", rnd_valid, 0);
    check("load_seeded", seeded, (EXP_WARM == 0));
    n = 0;
    while (!seeded && n < 100) begin
      check("warm_valid", rnd_valid, 0);
      tick();
      n++;
    end
    check("warm_len", n, EXP_WARM);
  endtask

  task automatic expect_word(input string tag, input logic [NREQ-1:0] g);
    tick();
    check({tag, "_gnt"}, gnt, g);
    check({tag, "_valid"}, rnd_valid, 1);
    check({tag, "_data"}, rnd_data, m_lane[m_ptr]);
    check({tag, "_lane"}, rnd_lane, m_ptr);
    m_lane[m_ptr] = ref_next(m_lane[m_ptr]);
    m_ptr = (m_ptr + 1) % 4;
  endtask

  logic [15:0] t2_data [5];
  logic [3:0]  t3_gnt  [5];
  logic [3:0]  t4_gnt  [6];
  logic [3:0]  t4_req  [6];

  initial begin
    t2_data = '{16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0002};
    t3_gnt  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    t4_req  = '{4'b0101, 4'b0101, 4'b0101, 4'b0111, 4'b0111, 4'b0111};
    t4_gnt  = '{4'b0100, 4'b0001, 4'b0100, 4'b0001, 4'b0010, 4'b0100};

    reset = 1'b1; seed_load = 1'b0; seed = '0; req = '0;
    #3;
    check("rst_gnt", gnt, 0);
    check("rst_valid", rnd_valid, 0);
    check("rst_data", rnd_data, 0);
    check("rst_lane", rnd_lane, 0);
    check("rst_seeded", seeded, 0);
    #4 reset = 1'b0;

    // Unseeded: requests are ignored.
    req = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("unseeded_gnt", gnt, 0);
    end

    // Lane rotation with a single requester; load wins over req on the load edge.
    do_load(64'h0004_0003_0002_0001, 4'b0001);
    for (int i = 0; i < 5; i++) begin
      expect_word("t2", 4'b0001);
`ifndef PRNG_ARB_WARMUP_EN
      check("t2_hand", rnd_data, t2_data[i]);
`endif
    end

    // Zero seed substitution and full round-robin.
    do_load(64'h0, 4'b1111);
    for (int i = 0; i < 5; i++) begin
      expect_word("t3", t3_gnt[i]);
`ifndef PRNG_ARB_WARMUP_EN
      if (i < 4) check("t3_hand", rnd_data, 16'h0001);
`endif
    end

    // Sparse requesters, then req[1] joins mid-stream.
    for (int i = 0; i < 6; i++) begin
      req = t4_req[i];
      expect_word("t4", t4_gnt[i]);
    end

    // Reload in READY with req high: rotation and priority restart on the new seed.
    do_load(64'h1234_0000_ABCD_8001, 4'b1111);
    expect_word("t5", 4'b0001);
    expect_word("t5", 4'b0010);
    expect_word("t5", 4'b0100);
    expect_word("t5", 4'b1000);

    // Asynchronous reset between edges.
    #3 reset = 1'b1;
    #1;
    check("arst_gnt", gnt, 0);
    check("arst_valid", rnd_valid, 0);
    check("arst_data", rnd_data, 0);
    check("arst_lane", rnd_lane, 0);
    check("arst_seeded", seeded, 0);
    #2 reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("arst_ignore", gnt, 0);
    end

    do_load(64'h0000_0000_0000_0005, 4'b1111);
    expect_word("t6", 4'b0001);
    expect_word("t6", 4'b0010);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
